// File: rtl/layer_tile_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : layer_tile_scheduler
// Purpose  : Walks one convolution layer tile by tile (filter group, output
//            row, column tile) and hands each tile's bases to the controller.
// Revision : 1.0 - initial release
// ============================================================================

module layer_tile_scheduler #(
    parameter int SYSTOLIC_SIZE    = 16,
    parameter int IFM_SIZE         = 416,
    parameter int OFM_SIZE         = 414,
    parameter int NO_FILTER        = 16,
    parameter int WGT_GROUP_STRIDE = 27,
    parameter int IFM_ADDR_WIDTH   = 19,
    parameter int WGT_ADDR_WIDTH   = 9,
    parameter int OFM_ADDR_WIDTH   = 22
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 layer_start,
    input  logic                                 tile_done,
    output logic                                 tile_start,
    output logic [IFM_ADDR_WIDTH-1:0]            ifm_base,
    output logic [WGT_ADDR_WIDTH-1:0]            wgt_base,
    output logic [OFM_ADDR_WIDTH-1:0]            ofm_base,
    output logic [$clog2(SYSTOLIC_SIZE+1)-1:0]   tile_valid_cols,
    output logic                                 busy,
    output logic                                 layer_done
);

    localparam int     c_col_tiles      = (OFM_SIZE + SYSTOLIC_SIZE - 1) / SYSTOLIC_SIZE;
    localparam int     c_fgroups        = (NO_FILTER + SYSTOLIC_SIZE - 1) / SYSTOLIC_SIZE;
    localparam int     c_last_cols      = OFM_SIZE - (c_col_tiles - 1) * SYSTOLIC_SIZE;
    localparam int     c_cols_w         = $clog2(SYSTOLIC_SIZE + 1);
    localparam int     c_fg_w           = (c_fgroups > 1) ? $clog2(c_fgroups) : 1;
    localparam int     c_row_w          = (OFM_SIZE > 1) ? $clog2(OFM_SIZE) : 1;
    localparam int     c_ct_w           = (c_col_tiles > 1) ? $clog2(c_col_tiles) : 1;
    localparam longint c_ofm_grp_stride = longint'(SYSTOLIC_SIZE) * OFM_SIZE * OFM_SIZE;

    // Address widths are parameters; a configuration whose largest base does
    // not fit the chosen width is a parameter error and wraps silently.
    localparam logic [IFM_ADDR_WIDTH-1:0] c_ifm_row_step = IFM_ADDR_WIDTH'(IFM_SIZE);
    localparam logic [IFM_ADDR_WIDTH-1:0] c_ifm_col_step = IFM_ADDR_WIDTH'(SYSTOLIC_SIZE);
    localparam logic [OFM_ADDR_WIDTH-1:0] c_ofm_row_step = OFM_ADDR_WIDTH'(OFM_SIZE);
    localparam logic [OFM_ADDR_WIDTH-1:0] c_ofm_col_step = OFM_ADDR_WIDTH'(SYSTOLIC_SIZE);
    localparam logic [OFM_ADDR_WIDTH-1:0] c_ofm_grp_step = OFM_ADDR_WIDTH'(c_ofm_grp_stride);
    localparam logic [WGT_ADDR_WIDTH-1:0] c_wgt_step     = WGT_ADDR_WIDTH'(WGT_GROUP_STRIDE);

    localparam logic [c_fg_w-1:0]   c_fg_last  = c_fg_w'(c_fgroups - 1);
    localparam logic [c_row_w-1:0]  c_row_last = c_row_w'(OFM_SIZE - 1);
    localparam logic [c_ct_w-1:0]   c_ct_last  = c_ct_w'(c_col_tiles - 1);
    localparam logic [c_ct_w-1:0]   c_ct_pen   = c_ct_w'((c_col_tiles > 1) ? c_col_tiles - 2 : 0);

    localparam logic [c_cols_w-1:0] c_cols_full  = c_cols_w'(SYSTOLIC_SIZE);
    localparam logic [c_cols_w-1:0] c_cols_last  = c_cols_w'(c_last_cols);
    localparam logic [c_cols_w-1:0] c_cols_first = (c_col_tiles == 1) ? c_cols_last : c_cols_full;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT    = 3'd2,
        S_ADVANCE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                  r_state;
    logic [c_fg_w-1:0]       r_fg;
    logic [c_row_w-1:0]      r_row;
    logic [c_ct_w-1:0]       r_ct;
    logic [IFM_ADDR_WIDTH-1:0] r_ifm_row_base;
    logic [OFM_ADDR_WIDTH-1:0] r_ofm_row_base;
    logic [OFM_ADDR_WIDTH-1:0] r_ofm_grp_base;

    logic                      w_ct_last;
    logic                      w_row_last;
    logic                      w_fg_last;
    logic [IFM_ADDR_WIDTH-1:0] w_ifm_next_row;
    logic [OFM_ADDR_WIDTH-1:0] w_ofm_next_row;
    logic [OFM_ADDR_WIDTH-1:0] w_ofm_next_grp;

    assign w_ct_last      = (r_ct == c_ct_last);
    assign w_row_last     = (r_row == c_row_last);
    assign w_fg_last      = (r_fg == c_fg_last);
    assign w_ifm_next_row = r_ifm_row_base + c_ifm_row_step;
    assign w_ofm_next_row = r_ofm_row_base + c_ofm_row_step;
    assign w_ofm_next_grp = r_ofm_grp_base + c_ofm_grp_step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_fg            <= '0;
            r_row           <= '0;
            r_ct            <= '0;
            r_ifm_row_base  <= '0;
            r_ofm_row_base  <= '0;
            r_ofm_grp_base  <= '0;
            ifm_base        <= '0;
            wgt_base        <= '0;
            ofm_base        <= '0;
            tile_valid_cols <= c_cols_first;
            tile_start      <= 1'b0;
            busy            <= 1'b0;
            layer_done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (layer_start) begin
                        r_state    <= S_ISSUE;
                        tile_start <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    tile_start <= 1'b0;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (tile_done) begin
                        r_state <= S_ADVANCE;
                    end
                end
                S_ADVANCE: begin
                    if (w_ct_last && w_row_last && w_fg_last) begin
                        r_state    <= S_DONE;
                        layer_done <= 1'b1;
                    end else begin
                        r_state    <= S_ISSUE;
                        tile_start <= 1'b1;
                        if (!w_ct_last) begin
                            r_ct            <= r_ct + c_ct_w'(1);
                            ifm_base        <= ifm_base + c_ifm_col_step;
                            ofm_base        <= ofm_base + c_ofm_col_step;
                            tile_valid_cols <= (r_ct == c_ct_pen) ? c_cols_last : c_cols_full;
                        end else begin
                            r_ct            <= '0;
                            tile_valid_cols <= c_cols_first;
                            if (!w_row_last) begin
                                r_row          <= r_row + c_row_w'(1);
                                r_ifm_row_base <= w_ifm_next_row;
                                ifm_base       <= w_ifm_next_row;
                                r_ofm_row_base <= w_ofm_next_row;
                                ofm_base       <= w_ofm_next_row;
                            end else begin
                                // New filter group: OFM jumps to the next plane set, IFM restarts
                                r_row          <= '0;
                                r_fg           <= r_fg + c_fg_w'(1);
                                r_ifm_row_base <= '0;
                                ifm_base       <= '0;
                                r_ofm_grp_base <= w_ofm_next_grp;
                                r_ofm_row_base <= w_ofm_next_grp;
                                ofm_base       <= w_ofm_next_grp;
                                wgt_base       <= wgt_base + c_wgt_step;
                            end
                        end
                    end
                end
                S_DONE: begin
                    r_state         <= S_IDLE;
                    layer_done      <= 1'b0;
                    busy            <= 1'b0;
                    r_fg            <= '0;
                    r_row           <= '0;
                    r_ct            <= '0;
                    r_ifm_row_base  <= '0;
                    r_ofm_row_base  <= '0;
                    r_ofm_grp_base  <= '0;
                    ifm_base        <= '0;
                    wgt_base        <= '0;
                    ofm_base        <= '0;
                    tile_valid_cols <= c_cols_first;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_layer_tile_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_layer_tile_scheduler
// Purpose  : Scoreboard bench for layer_tile_scheduler, small and default configs.
// Revision : 1.0 - initial release
// ============================================================================

module tb_layer_tile_scheduler;

    typedef struct {
        longint ifm;
        longint wgt;
        longint ofm;
        longint cols;
    } tile_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Small configuration
    logic        ls_s, td_s, ts_s, busy_s, ld_s;
    logic [18:0] ifm_s;
    logic [8:0]  wgt_s;
    logic [21:0] ofm_s;
    logic [2:0]  cols_s;

    // Default configuration
    logic        ls_d, td_d, ts_d, busy_d, ld_d;
    logic [18:0] ifm_d;
    logic [8:0]  wgt_d;
    logic [21:0] ofm_d;
    logic [4:0]  cols_d;

    layer_tile_scheduler #(
        .SYSTOLIC_SIZE(4), .IFM_SIZE(7), .OFM_SIZE(5), .NO_FILTER(8), .WGT_GROUP_STRIDE(27),
        .IFM_ADDR_WIDTH(19), .WGT_ADDR_WIDTH(9), .OFM_ADDR_WIDTH(22)
    ) dut_s (
        .clk(clk), .rst_n(rst_n), .layer_start(ls_s), .tile_done(td_s),
        .tile_start(ts_s), .ifm_base(ifm_s), .wgt_base(wgt_s), .ofm_base(ofm_s),
        .tile_valid_cols(cols_s), .busy(busy_s), .layer_done(ld_s)
    );

    layer_tile_scheduler dut_d (
        .clk(clk), .rst_n(rst_n), .layer_start(ls_d), .tile_done(td_d),
        .tile_start(ts_d), .ifm_base(ifm_d), .wgt_base(wgt_d), .ofm_base(ofm_d),
        .tile_valid_cols(cols_d), .busy(busy_d), .layer_done(ld_d)
    );

    int n_pass  = 0;
    int n_total = 0;

    int delay = 3;
    bit noisy = 1'b0;
    bit act_d = 1'b0;
    int last_done_cyc = -100;

    tile_t q_s[$];
    tile_t q_d[$];

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s: got no event, required one within the cycle budget", name);
    endtask

    // Expected tiles straight from the closed-form address equations
    task automatic push_tiles(input bit dflt, input int limit);
        int s, ifw, o, nf, st, ctn, fgn, k;
        tile_t t;
        if (dflt) begin s = 16; ifw = 416; o = 414; nf = 16; st = 27; end
        else      begin s = 4;  ifw = 7;   o = 5;   nf = 8;  st = 27; end
        ctn = (o + s - 1) / s;
        fgn = (nf + s - 1) / s;
        k = 0;
        for (int fg = 0; fg < fgn; fg++)
            for (int row = 0; row < o; row++)
                for (int ct = 0; ct < ctn; ct++)
                    if (k < limit) begin
                        t.ifm  = longint'(row) * ifw + longint'(ct) * s;
                        t.wgt  = longint'(fg) * st;
                        t.ofm  = longint'(fg) * s * o * o + longint'(row) * o + longint'(ct) * s;
                        t.cols = (ct == ctn - 1) ? o - (ctn - 1) * s : s;
                        if (dflt) q_d.push_back(t); else q_s.push_back(t);
                        k++;
                    end
    endtask

    // Controller model: answers tile_start with tile_done after `delay` cycles
    initial begin : responder
        int   cnt;
        bit   waiting;
        logic ts, td;
        cnt = 0; waiting = 1'b0; td_s = 1'b0; td_d = 1'b0;
        forever begin
            @(negedge clk);
            ts = act_d ? ts_d : ts_s;
            if (!rst_n) begin
                waiting = 1'b0; td = 1'b0;
            end else if (ts) begin
                waiting = 1'b1; cnt = delay; td = noisy;
            end else if (waiting) begin
                cnt--;
                if (cnt == 0) begin
                    td = 1'b1; waiting = 1'b0; last_done_cyc = cyc;
                end else begin
                    td = 1'b0;
                end
            end else begin
                td = noisy;
            end
            td_s = act_d ? 1'b0 : td;
            td_d = act_d ? td : 1'b0;
        end
    end

    // Small-config monitor
    int     s_starts = 0, s_ld = 0, s_prev = -1, s_idx = 0, s_ldc = -100;
    bit     s_bprev = 1'b0;
    tile_t  te_s;
    longint s_seen_ifm[20], s_seen_wgt[20], s_seen_ofm[20], s_seen_cols[20];

    always @(negedge clk) begin
        if (!rst_n) begin
            s_prev = -1; s_idx = 0; s_bprev = 1'b0;
        end else begin
            if (ts_s) begin
                s_starts++;
                if (q_s.size() == 0) fail_now("s_expected_tile_available");
                else begin
                    te_s = q_s.pop_front();
                    chk("s_ifm_base", ifm_s, te_s.ifm);
                    chk("s_wgt_base", wgt_s, te_s.wgt);
                    chk("s_ofm_base", ofm_s, te_s.ofm);
                    chk("s_tile_valid_cols", cols_s, te_s.cols);
                end
                if (s_prev >= 0) chk("s_tile_interval", cyc - s_prev, delay + 2);
                s_prev = cyc;
                if (s_idx < 20) begin
                    s_seen_ifm[s_idx] = ifm_s;  s_seen_wgt[s_idx] = wgt_s;
                    s_seen_ofm[s_idx] = ofm_s;  s_seen_cols[s_idx] = cols_s;
                end
                s_idx++;
            end
            if (ld_s) begin
                s_ld++;
                chk("s_layer_done_latency", cyc, last_done_cyc + 2);
                s_ldc = cyc; s_prev = -1; s_idx = 0;
            end
            if (s_bprev && !busy_s) chk("s_busy_fall", cyc, s_ldc + 1);
            s_bprev = busy_s;
        end
    end

    // Default-config monitor
    int     d_starts = 0, d_ld = 0, d_prev = -1, d_ldc = -100;
    bit     d_bprev = 1'b0;
    tile_t  te_d;
    longint d_last_ifm = 0, d_last_wgt = 0, d_last_ofm = 0, d_last_cols = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            d_prev = -1; d_bprev = 1'b0;
        end else begin
            if (ts_d) begin
                d_starts++;
                if (q_d.size() == 0) fail_now("d_expected_tile_available");
                else begin
                    te_d = q_d.pop_front();
                    chk("d_ifm_base", ifm_d, te_d.ifm);
                    chk("d_wgt_base", wgt_d, te_d.wgt);
                    chk("d_ofm_base", ofm_d, te_d.ofm);
                    chk("d_tile_valid_cols", cols_d, te_d.cols);
                end
                if (d_prev >= 0) chk("d_tile_interval", cyc - d_prev, delay + 2);
                d_prev = cyc;
                d_last_ifm = ifm_d; d_last_wgt = wgt_d; d_last_ofm = ofm_d; d_last_cols = cols_d;
            end
            if (ld_d) begin
                d_ld++;
                chk("d_layer_done_latency", cyc, last_done_cyc + 2);
                d_ldc = cyc; d_prev = -1;
            end
            if (d_bprev && !busy_d) chk("d_busy_fall", cyc, d_ldc + 1);
            d_bprev = busy_d;
        end
    end

    task automatic pulse_start(input bit dflt);
        @(negedge clk);
        if (dflt) ls_d = 1'b1; else ls_s = 1'b1;
        @(negedge clk);
        ls_d = 1'b0; ls_s = 1'b0;
    endtask

    // Waits for layer_done; with spam, re-requests layer_start while busy
    task automatic run_wait(input bit dflt, input int bound, input bit spam);
        int n, ld0;
        n = 0;
        ld0 = dflt ? d_ld : s_ld;
        while (((dflt ? d_ld : s_ld) == ld0) && n < bound) begin
            @(negedge clk); #1;
            n++;
            ls_s = (spam && !dflt && busy_s && (n % 7 == 0));
        end
        ls_s = 1'b0;
        if (n >= bound) fail_now(dflt ? "d_layer_done_timeout" : "s_layer_done_timeout");
        repeat (3) @(negedge clk);
    endtask

    task automatic check_reset_s(input string tag);
        chk({tag, "_tile_start"}, ts_s, 0);
        chk({tag, "_busy"}, busy_s, 0);
        chk({tag, "_layer_done"}, ld_s, 0);
        chk({tag, "_ifm_base"}, ifm_s, 0);
        chk({tag, "_wgt_base"}, wgt_s, 0);
        chk({tag, "_ofm_base"}, ofm_s, 0);
        chk({tag, "_tile_valid_cols"}, cols_s, 4);
    endtask

    task automatic run_small(input string tag, input bit spam);
        int st0, ld0;
        st0 = s_starts; ld0 = s_ld;
        push_tiles(1'b0, 1000);
        pulse_start(1'b0);
        run_wait(1'b0, 500, spam);
        chk({tag, "_tile_count"}, s_starts - st0, 20);
        chk({tag, "_layer_done_count"}, s_ld - ld0, 1);
        chk({tag, "_queue_drained"}, q_s.size(), 0);
        chk({tag, "_busy_idle"}, busy_s, 0);
    endtask

    initial begin : main
        int n, st0, ld0;
        rst_n = 1'b0; ls_s = 1'b0; ls_d = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_s("rst");
        chk("rst_d_tile_valid_cols", cols_d, 16);
        chk("rst_d_busy", busy_d, 0);
        rst_n = 1'b1;

        // Basic run with a 3-cycle controller
        delay = 3;
        run_small("s1", 1'b0);
        chk("t0_ifm", s_seen_ifm[0], 0);   chk("t0_ofm", s_seen_ofm[0], 0);
        chk("t0_wgt", s_seen_wgt[0], 0);   chk("t0_cols", s_seen_cols[0], 4);
        chk("t1_ifm", s_seen_ifm[1], 4);   chk("t1_ofm", s_seen_ofm[1], 4);
        chk("t1_cols", s_seen_cols[1], 1);
        chk("t2_ifm", s_seen_ifm[2], 7);   chk("t2_ofm", s_seen_ofm[2], 5);
        chk("t10_wgt", s_seen_wgt[10], 27); chk("t10_ofm", s_seen_ofm[10], 100);
        chk("t10_ifm", s_seen_ifm[10], 0);
        chk("t19_ifm", s_seen_ifm[19], 32); chk("t19_ofm", s_seen_ofm[19], 124);

        // Spurious layer_start and tile_done outside WAIT
        noisy = 1'b1;
        run_small("s3", 1'b1);
        noisy = 1'b0;
        chk("s3_t19_ifm", s_seen_ifm[19], 32);
        chk("s3_t10_wgt", s_seen_wgt[10], 27);

        // Fastest controller: next tile_start 3 cycles later
        delay = 1;
        run_small("s4", 1'b0);

        // Reset during WAIT of tile 7
        delay = 3;
        st0 = s_starts; ld0 = s_ld;
        push_tiles(1'b0, 8);
        pulse_start(1'b0);
        n = 0;
        while ((s_starts - st0) < 8 && n < 200) begin @(negedge clk); #1; n++; end
        if (n >= 200) fail_now("s5_tile7_timeout");
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_reset_s("s5_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("s5_no_layer_done", s_ld - ld0, 0);
        chk("s5_tile_count_at_abort", s_starts - st0, 8);
        chk("s5_queue_drained", q_s.size(), 0);
        chk("s5_idle_busy", busy_s, 0);
        run_small("s5r", 1'b0);
        chk("s5r_t0_ifm", s_seen_ifm[0], 0);
        chk("s5r_t0_ofm", s_seen_ofm[0], 0);

        // Full layer at default parameters
        act_d = 1'b1; delay = 1;
        st0 = d_starts; ld0 = d_ld;
        push_tiles(1'b1, 20000);
        pulse_start(1'b1);
        run_wait(1'b1, 40000, 1'b0);
        chk("d_tile_count", d_starts - st0, 10764);
        chk("d_layer_done_count", d_ld - ld0, 1);
        chk("d_queue_drained", q_d.size(), 0);
        chk("d_final_ifm", d_last_ifm, 172208);
        chk("d_final_ofm", d_last_ofm, 171382);
        chk("d_final_cols", d_last_cols, 14);
        chk("d_final_wgt", d_last_wgt, 0);
        chk("d_busy_idle", busy_d, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
